// File: rtl/riscv_pkg.sv
// Shared opcode/ALU constants, FSM state and instruction-class types for the
// multi-cycle RISC-V control unit.
package riscv_pkg;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] RTypeI = 7'b0010011;
    localparam logic [6:0] LW     = 7'b0000011;
    localparam logic [6:0] SW     = 7'b0100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b1100;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXEC    = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4,
        ST_ILLEGAL = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_I   = 3'd1,
        CLS_LW  = 3'd2,
        CLS_SW  = 3'd3,
        CLS_BAD = 3'd4
    } cls_t;

    function automatic cls_t opcode_class(input logic [6:0] op);
        cls_t cls;
        case (op)
            R_TYPE:  cls = CLS_R;
            RTypeI:  cls = CLS_I;
            LW:      cls = CLS_LW;
            SW:      cls = CLS_SW;
            default: cls = CLS_BAD;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decode.sv
// Combinational map from instruction class/funct7/funct3 to ALU code and
// encoding legality; the controller samples it only in DECODE.
module alu_decode
    import riscv_pkg::*;
(
    input  cls_t        cls_i,
    input  logic [6:0]  funct7_i,
    input  logic [2:0]  funct3_i,
    output logic [3:0]  alu_cc_o,
    output logic        legal_o
);

    logic [3:0] base_cc_s;
    logic       base_ok_s;

    // funct3 -> operation shared by R-type and I-type arithmetic
    always_comb begin
        base_cc_s = ALU_ADD;
        base_ok_s = 1'b0;
        case (funct3_i)
            3'b000: begin base_cc_s = ALU_ADD; base_ok_s = 1'b1; end
            3'b100: begin base_cc_s = ALU_XOR; base_ok_s = 1'b1; end
            3'b110: begin base_cc_s = ALU_OR;  base_ok_s = 1'b1; end
            3'b111: begin base_cc_s = ALU_AND; base_ok_s = 1'b1; end
            3'b010: begin base_cc_s = ALU_SLT; base_ok_s = 1'b1; end
            default: begin base_cc_s = ALU_ADD; base_ok_s = 1'b0; end
        endcase
    end

    // class-specific refinement; funct7 only matters for R-type
    always_comb begin
        alu_cc_o = ALU_ADD;
        legal_o  = 1'b0;
        case (cls_i)
            CLS_R: begin
                if (funct7_i == F7_BASE) begin
                    alu_cc_o = base_cc_s;
                    legal_o  = base_ok_s;
                end else if (funct7_i == F7_ALT) begin
                    alu_cc_o = ALU_SUB;
                    legal_o  = (funct3_i == 3'b000);
                end else begin
                    alu_cc_o = ALU_ADD;
                    legal_o  = 1'b0;
                end
            end
            CLS_I: begin
                alu_cc_o = base_cc_s;
                legal_o  = base_ok_s;
            end
            CLS_LW, CLS_SW: begin
                alu_cc_o = ALU_ADD;
                legal_o  = (funct3_i == 3'b010);
            end
            default: begin
                alu_cc_o = ALU_ADD;
                legal_o  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving data_path controls.
// Build option CTRL_ILLEGAL_HALT_EN makes the ILLEGAL state terminal.
module multicycle_ctrl
    import riscv_pkg::*;
#(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic [6:0]           funct7,
    input  logic [2:0]           funct3,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic                 mem2reg,
    output logic                 alu_src,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [3:0]           alu_cc,
    output logic                 illegal,
    output logic [INSTRET_W-1:0] instret
);

    state_t                state_q, state_d;
    cls_t                  cls_q;
    logic [3:0]            alu_cc_q;
    logic                  illegal_q;
    logic [INSTRET_W-1:0]  instret_q;

    cls_t                  dec_cls_s;
    logic [3:0]            dec_cc_s;
    logic                  dec_legal_s;
    logic                  retire_s;

    assign dec_cls_s = opcode_class(opcode);

    alu_decode u_alu_decode (
        .cls_i    (dec_cls_s),
        .funct7_i (funct7),
        .funct3_i (funct3),
        .alu_cc_o (dec_cc_s),
        .legal_o  (dec_legal_s)
    );

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic; opcode fields are looked at only in DECODE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_ready) state_d = ST_DECODE;
                else            state_d = ST_FETCH;
            end
            ST_DECODE: begin
                if (dec_legal_s) state_d = ST_EXEC;
                else             state_d = ST_ILLEGAL;
            end
            ST_EXEC: begin
                if (cls_q == CLS_LW || cls_q == CLS_SW) state_d = ST_MEM;
                else                                    state_d = ST_WB;
            end
            ST_MEM: begin
                if (!dmem_ready)          state_d = ST_MEM;
                else if (cls_q == CLS_LW) state_d = ST_WB;
                else                      state_d = ST_FETCH;
            end
            ST_WB: state_d = ST_FETCH;
            ST_ILLEGAL: begin
`ifdef CTRL_ILLEGAL_HALT_EN
                state_d = ST_ILLEGAL;
`else
                state_d = ST_FETCH;
`endif
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // latched decode fields, sticky illegal flag and retire counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cls_q     <= CLS_R;
            alu_cc_q  <= 4'b0000;
            illegal_q <= 1'b0;
            instret_q <= {INSTRET_W{1'b0}};
        end else begin
            if (state_q == ST_DECODE) begin
                cls_q    <= dec_cls_s;
                alu_cc_q <= dec_cc_s;
            end
            if (state_q == ST_DECODE && !dec_legal_s) begin
                illegal_q <= 1'b1;
            end
            if (retire_s) begin
                instret_q <= instret_q + {{(INSTRET_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // output decode from state and latched fields; ir_write is masked by
    // reset so nothing is enabled while the FSM sits in FETCH under reset
    always_comb begin
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        mem2reg   = 1'b0;
        alu_src   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        alu_cc    = 4'b0000;
        retire_s  = 1'b0;
        case (state_q)
            ST_FETCH: ir_write = imem_ready & ~reset;
            ST_EXEC: begin
                alu_cc  = alu_cc_q;
                alu_src = (cls_q != CLS_R);
            end
            ST_MEM: begin
                alu_cc  = alu_cc_q;
                alu_src = 1'b1;
                if (cls_q == CLS_LW) begin
                    mem_read = 1'b1;
                end else begin
                    mem_write = 1'b1;
                    pc_write  = dmem_ready;
                    retire_s  = dmem_ready;
                end
            end
            ST_WB: begin
                alu_cc    = alu_cc_q;
                alu_src   = (cls_q != CLS_R);
                reg_write = 1'b1;
                mem2reg   = (cls_q == CLS_LW);
                pc_write  = 1'b1;
                retire_s  = 1'b1;
            end
            ST_ILLEGAL: begin
`ifdef CTRL_ILLEGAL_HALT_EN
                pc_write = 1'b0;
`else
                pc_write = 1'b1;
`endif
            end
            default: ir_write = 1'b0;
        endcase
    end

    assign illegal = illegal_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: table-driven directed encodings,
// a mid-store reset sequence and random instructions with random wait states.
module tb_multicycle_ctrl;

    localparam int IW = 4;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [6:0]    opcode = 7'b0;
    logic [6:0]    funct7 = 7'b0;
    logic [2:0]    funct3 = 3'b0;
    logic          imem_ready = 1'b0;
    logic          dmem_ready = 1'b0;
    logic          ir_write, pc_write, reg_write, mem2reg, alu_src;
    logic          mem_read, mem_write, illegal;
    logic [3:0]    alu_cc;
    logic [IW-1:0] instret;
    logic [11:0]   got_v;

    always #5 clk = ~clk;

    multicycle_ctrl #(.INSTRET_W(IW)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct7     (funct7),
        .funct3     (funct3),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .mem2reg    (mem2reg),
        .alu_src    (alu_src),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .alu_cc     (alu_cc),
        .illegal    (illegal),
        .instret    (instret)
    );

    assign got_v = {ir_write, pc_write, reg_write, mem2reg, alu_src,
                    mem_read, mem_write, alu_cc, illegal};

    int n_cmp = 0;
    int n_fail = 0;
    int exp_instret = 0;
    bit exp_illegal = 1'b0;

    typedef struct {
        logic [6:0] op;
        logic [6:0] f7;
        logic [2:0] f3;
        int         cls;   // 0 R, 1 I, 2 LW, 3 SW, 4 other
        logic [3:0] cc;
        bit         ok;
        int         iw;
        int         dw;
    } vec_t;

    vec_t vecs [$];

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    function automatic logic [16:0] rf();
        return 17'($urandom);
    endfunction

    // expected output word: ir pc rw m2r src mr mw cc[3:0] illegal
    function automatic logic [11:0] mk(bit ir, bit pc, bit rw, bit m2r, bit src,
                                       bit mr, bit mw, logic [3:0] cc);
        return {ir, pc, rw, m2r, src, mr, mw, cc, exp_illegal};
    endfunction

    // reference decode straight from the instruction-set rules
    function automatic void ref_decode(input logic [6:0] op, input logic [6:0] f7,
                                       input logic [2:0] f3, output int cls,
                                       output logic [3:0] cc, output bit ok);
        logic [3:0] cc_tab [0:7];
        bit         ok_tab [0:7];
        cc_tab = '{4'b0010, 4'b0000, 4'b0111, 4'b0000, 4'b1100, 4'b0000, 4'b0001, 4'b0000};
        ok_tab = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        if (op == OP_R) cls = 0;
        else if (op == OP_I) cls = 1;
        else if (op == OP_LW) cls = 2;
        else if (op == OP_SW) cls = 3;
        else cls = 4;
        cc = 4'b0010;
        ok = 1'b0;
        if (cls == 2 || cls == 3) begin
            ok = (f3 == 3'b010);
        end else if (cls == 1 || (cls == 0 && f7 == 7'b0000000)) begin
            cc = cc_tab[f3];
            ok = ok_tab[f3];
        end else if (cls == 0 && f7 == 7'b0100000) begin
            cc = 4'b0110;
            ok = (f3 == 3'b000);
        end
    endfunction

    // one clock: drive at posedge+1, compare at negedge, then advance
    task automatic cycle(input string tag, input bit im, input bit dm,
                         input logic [16:0] fields, input logic [11:0] exp_v,
                         input bit ret);
        imem_ready = im;
        dmem_ready = dm;
        {opcode, funct7, funct3} = fields;
        @(negedge clk);
        n_cmp++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: outputs(ir pc rw m2r src mr mw cc ill) got %b want %b",
                     tag, got_v, exp_v);
        end
        n_cmp++;
        if (instret !== IW'(exp_instret)) begin
            n_fail++;
            $display("FAIL %s: instret got %0d want %0d", tag, instret, exp_instret);
        end
        @(posedge clk);
        #1;
        if (ret) exp_instret = (exp_instret + 1) % (1 << IW);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        #1;
        exp_illegal = 1'b0;
        exp_instret = 0;
        n_cmp++;
        if (got_v !== 12'b0 || instret !== IW'(0)) begin
            n_fail++;
            $display("FAIL %s.reset: outputs got %b instret %0d want all zero",
                     tag, got_v, instret);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_instr(input string tag, input logic [6:0] op, input logic [6:0] f7,
                             input logic [2:0] f3, input int cls, input logic [3:0] cc,
                             input bit ok, input int iw, input int dw);
        bit ld, st, src;
        ld  = (cls == 2);
        st  = (cls == 3);
        src = (cls != 0);
        for (int i = 0; i < iw; i++)
            cycle({tag, ".fetch_wait"}, 1'b0, rb(), rf(), mk(0,0,0,0,0,0,0,4'b0), 1'b0);
        cycle({tag, ".fetch"}, 1'b1, rb(), rf(), mk(1,0,0,0,0,0,0,4'b0), 1'b0);
        cycle({tag, ".decode"}, rb(), rb(), {op, f7, f3}, mk(0,0,0,0,0,0,0,4'b0), 1'b0);
        if (!ok) begin
            exp_illegal = 1'b1;
`ifdef CTRL_ILLEGAL_HALT_EN
            for (int i = 0; i < 4; i++)
                cycle({tag, ".halt"}, rb(), rb(), rf(), mk(0,0,0,0,0,0,0,4'b0), 1'b0);
            do_reset(tag);
`else
            cycle({tag, ".illegal"}, rb(), rb(), rf(), mk(0,1,0,0,0,0,0,4'b0), 1'b0);
`endif
            return;
        end
        cycle({tag, ".exec"}, rb(), rb(), rf(), mk(0,0,0,0,src,0,0,cc), 1'b0);
        if (ld || st) begin
            for (int i = 0; i < dw; i++)
                cycle({tag, ".mem_wait"}, rb(), 1'b0, rf(), mk(0,0,0,0,1,ld,st,cc), 1'b0);
            cycle({tag, ".mem"}, rb(), 1'b1, rf(), mk(0,st,0,0,1,ld,st,cc), st);
        end
        if (!st)
            cycle({tag, ".wb"}, rb(), rb(), rf(), mk(0,1,1,ld,src,0,0,cc), 1'b1);
    endtask

    initial begin
        vecs.push_back('{OP_R,  7'h00, 3'b000, 0, 4'b0010, 1'b1, 0, 0}); // add
        vecs.push_back('{OP_R,  7'h20, 3'b000, 0, 4'b0110, 1'b1, 0, 0}); // sub
        vecs.push_back('{OP_I,  7'h20, 3'b000, 1, 4'b0010, 1'b1, 0, 0}); // addi, funct7 ignored
        vecs.push_back('{OP_R,  7'h00, 3'b100, 0, 4'b1100, 1'b1, 1, 0}); // xor
        vecs.push_back('{OP_R,  7'h00, 3'b110, 0, 4'b0001, 1'b1, 0, 0}); // or
        vecs.push_back('{OP_R,  7'h00, 3'b111, 0, 4'b0000, 1'b1, 0, 0}); // and
        vecs.push_back('{OP_R,  7'h00, 3'b010, 0, 4'b0111, 1'b1, 2, 0}); // slt
        vecs.push_back('{OP_I,  7'h55, 3'b100, 1, 4'b1100, 1'b1, 0, 0}); // xori
        vecs.push_back('{OP_I,  7'h00, 3'b110, 1, 4'b0001, 1'b1, 0, 0}); // ori
        vecs.push_back('{OP_I,  7'h7f, 3'b111, 1, 4'b0000, 1'b1, 0, 0}); // andi
        vecs.push_back('{OP_I,  7'h00, 3'b010, 1, 4'b0111, 1'b1, 0, 0}); // slti
        vecs.push_back('{OP_LW, 7'h00, 3'b010, 2, 4'b0010, 1'b1, 0, 3}); // lw, 3 waits
        vecs.push_back('{OP_SW, 7'h00, 3'b010, 3, 4'b0010, 1'b1, 0, 0}); // sw
        vecs.push_back('{OP_LW, 7'h00, 3'b010, 2, 4'b0010, 1'b1, 0, 0}); // lw no wait
        vecs.push_back('{7'b1100011, 7'h00, 3'b000, 4, 4'b0010, 1'b0, 0, 0}); // branch
        vecs.push_back('{OP_R,  7'h01, 3'b000, 0, 4'b0010, 1'b0, 0, 0}); // bad funct7
        vecs.push_back('{OP_R,  7'h20, 3'b100, 0, 4'b0010, 1'b0, 0, 0}); // sub form on xor
        vecs.push_back('{OP_R,  7'h00, 3'b001, 0, 4'b0010, 1'b0, 0, 0}); // sll
        vecs.push_back('{OP_I,  7'h00, 3'b101, 1, 4'b0010, 1'b0, 0, 0}); // srli
        vecs.push_back('{OP_I,  7'h00, 3'b011, 1, 4'b0010, 1'b0, 0, 0}); // sltiu
        vecs.push_back('{OP_LW, 7'h00, 3'b000, 2, 4'b0010, 1'b0, 0, 0}); // lb
        vecs.push_back('{OP_SW, 7'h00, 3'b110, 3, 4'b0010, 1'b0, 0, 0}); // bad store width

        #2;
        do_reset("init");

        for (int v = 0; v < vecs.size(); v++)
            run_instr($sformatf("vec%0d", v), vecs[v].op, vecs[v].f7, vecs[v].f3,
                      vecs[v].cls, vecs[v].cc, vecs[v].ok, vecs[v].iw, vecs[v].dw);

        // reset while a store is stalled in MEM
        run_instr("pre_rst", OP_R, 7'h00, 3'b000, 0, 4'b0010, 1'b1, 0, 0);
        cycle("rst_sw.fetch", 1'b1, rb(), rf(), mk(1,0,0,0,0,0,0,4'b0), 1'b0);
        cycle("rst_sw.decode", rb(), rb(), {OP_SW, 7'h00, 3'b010}, mk(0,0,0,0,0,0,0,4'b0), 1'b0);
        cycle("rst_sw.exec", rb(), rb(), rf(), mk(0,0,0,0,1,0,0,4'b0010), 1'b0);
        cycle("rst_sw.mem", rb(), 1'b0, rf(), mk(0,0,0,0,1,0,1,4'b0010), 1'b0);
        do_reset("rst_sw");
        run_instr("post_rst", OP_R, 7'h00, 3'b000, 0, 4'b0010, 1'b1, 0, 0);

        for (int k = 0; k < 60; k++) begin
            logic [6:0] op;
            logic [6:0] f7;
            logic [2:0] f3;
            int         c;
            logic [3:0] cc;
            bit         ok;
            case ($urandom_range(0, 4))
                0: op = OP_R;
                1: op = OP_I;
                2: op = OP_LW;
                3: op = OP_SW;
                default: op = 7'($urandom);
            endcase
            case ($urandom_range(0, 2))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            f3 = 3'($urandom);
            if ((op == OP_LW || op == OP_SW) && $urandom_range(0, 1) == 1) f3 = 3'b010;
            ref_decode(op, f7, f3, c, cc, ok);
            run_instr($sformatf("rnd%0d", k), op, f7, f3, c, cc, ok,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
